// File: rtl/hack_pkg.sv
// Shared definitions for the multi-cycle Hack CPU: FSM states, instruction
// field positions and the jump-condition decoder.
package hack_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        MREAD  = 2'd1,
        EXEC   = 2'd2,
        MWRITE = 2'd3
    } state_t;

    localparam int A_BIT   = 12;
    localparam int ALU_HI  = 11;
    localparam int ALU_LO  = 6;
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;
    localparam int JUMP_HI = 2;
    localparam int JUMP_LO = 0;

    localparam logic [2:0] JMP_NEVER = 3'b000;
    localparam logic [2:0] JMP_GT    = 3'b001;
    localparam logic [2:0] JMP_EQ    = 3'b010;
    localparam logic [2:0] JMP_GE    = 3'b011;
    localparam logic [2:0] JMP_LT    = 3'b100;
    localparam logic [2:0] JMP_NE    = 3'b101;
    localparam logic [2:0] JMP_LE    = 3'b110;
    localparam logic [2:0] JMP_ALWAYS = 3'b111;

    function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
        case (j)
            JMP_NEVER:  return 1'b0;
            JMP_GT:     return !ng && !zr;
            JMP_EQ:     return zr;
            JMP_GE:     return !ng;
            JMP_LT:     return ng;
            JMP_NE:     return !zr;
            JMP_LE:     return ng || zr;
            JMP_ALWAYS: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hack_cpu_mc_if.sv
// Instruction-fetch and data-access req/ack bus between the CPU (master)
// and the instruction ROM / data RAM side (slave).
interface hack_cpu_mc_if #(
    parameter int WIDTH = 16
) ();
    localparam int ADDR_W = WIDTH - 1;

    logic              imem_req;
    logic [WIDTH-1:0]  imem_addr;
    logic [WIDTH-1:0]  imem_rdata;
    logic              imem_ack;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [WIDTH-1:0]  dmem_wdata;
    logic [WIDTH-1:0]  dmem_rdata;
    logic              dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_rdata, imem_ack, dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_rdata, imem_ack, dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/hack_alu_w.sv
// Width-parametrised Hack ALU: zx/nx/zy/ny/f/no applied at WIDTH bits.
module hack_alu_w #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    input  logic        [5:0]       ctrl,
    output logic signed [WIDTH-1:0] out,
    output logic                    zr,
    output logic                    ng
);
    logic signed [WIDTH-1:0] xz, xn, yz, yn, fr;

    always_comb begin
        xz  = ctrl[5] ? '0 : x;
        xn  = ctrl[4] ? ~xz : xz;
        yz  = ctrl[3] ? '0 : y;
        yn  = ctrl[2] ? ~yz : yz;
        fr  = ctrl[1] ? (xn + yn) : (xn & yn);
        out = ctrl[0] ? ~fr : fr;
        zr  = (out == '0);
        ng  = out[WIDTH-1];
    end
endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with req/ack fetch and data ports. A/D update in EXEC;
// PC and the retire pulse wait for any pending data write to be acknowledged.
module hack_cpu_mc
    import hack_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             reset,
    hack_cpu_mc_if.master    bus,
    output logic [WIDTH-1:0] pc_out,
    output logic             retire
);
    localparam int ADDR_W = WIDTH - 1;

    state_t                  state, state_nx;
    logic                    boot;
    logic [WIDTH-1:0]        pc, ir, pc_hold, pc_seq;
    logic signed [WIDTH-1:0] a_reg, d_reg, mdr, wr_data, alu_y, alu_out;
    logic [ADDR_W-1:0]       wr_addr;
    logic                    alu_zr, alu_ng, is_c, wr_m, jmp, commit, ifire, dfire;

    assign is_c  = ir[WIDTH-1];
    assign wr_m  = is_c && ir[DEST_M];
    assign alu_y = ir[A_BIT] ? mdr : a_reg;

    hack_alu_w #(.WIDTH(WIDTH)) u_alu (
        .x    (d_reg),
        .y    (alu_y),
        .ctrl (ir[ALU_HI:ALU_LO]),
        .out  (alu_out),
        .zr   (alu_zr),
        .ng   (alu_ng)
    );

    // Jump target and write address both use A as it was before this instruction.
    assign jmp    = is_c && jump_taken(ir[JUMP_HI:JUMP_LO], alu_zr, alu_ng);
    assign pc_seq = jmp ? a_reg : pc + WIDTH'(1);

    // Acks only count while the matching request is actually being driven.
    assign ifire  = (state == FETCH) && !boot && bus.imem_ack;
    assign dfire  = ((state == MREAD) || (state == MWRITE)) && bus.dmem_ack;
    assign commit = ((state == EXEC) && !wr_m) || ((state == MWRITE) && dfire);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            boot  <= 1'b1;
        end else begin
            state <= state_nx;
            boot  <= 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            FETCH:  if (ifire)
                        state_nx = (bus.imem_rdata[WIDTH-1] && bus.imem_rdata[A_BIT]) ? MREAD : EXEC;
            MREAD:  if (dfire) state_nx = EXEC;
            EXEC:   state_nx = wr_m ? MWRITE : FETCH;
            MWRITE: if (dfire) state_nx = FETCH;
            default: state_nx = FETCH;
        endcase
    end

    // boot holds every request low for the first cycle out of reset.
    always_comb begin
        bus.imem_req   = (state == FETCH) && !boot;
        bus.imem_addr  = pc;
        bus.dmem_req   = (state == MREAD) || (state == MWRITE);
        bus.dmem_we    = (state == MWRITE);
        bus.dmem_addr  = (state == MWRITE) ? wr_addr : a_reg[ADDR_W-1:0];
        bus.dmem_wdata = wr_data;
        pc_out         = pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_VECTOR;
            a_reg  <= '0;
            d_reg  <= '0;
            ir     <= '0;
            retire <= 1'b0;
        end else begin
            retire <= commit;
            case (state)
                FETCH:  if (ifire) ir <= bus.imem_rdata;
                MREAD:  if (dfire) mdr <= bus.dmem_rdata;
                EXEC: begin
                    if (is_c) begin
                        if (ir[DEST_A]) a_reg <= alu_out;
                        if (ir[DEST_D]) d_reg <= alu_out;
                        wr_addr <= a_reg[ADDR_W-1:0];
                        wr_data <= alu_out;
                        pc_hold <= pc_seq;
                    end else begin
                        a_reg <= {1'b0, ir[WIDTH-2:0]};
                    end
                    if (commit) pc <= pc_seq;
                end
                MWRITE: if (dfire) pc <= pc_hold;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hack_cpu_mc.sv
// Scoreboard bench for hack_cpu_mc: 16-bit and 32-bit instances fed from
// small ROM/RAM models with programmable ack delay.
module tb_hack_cpu_mc;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

    localparam logic [6:0] C_ZERO = 7'b0101010, C_NEG1 = 7'b0111010, C_D   = 7'b0001100;
    localparam logic [6:0] C_A    = 7'b0110000, C_M    = 7'b1110000, C_DP1 = 7'b0011111;
    localparam logic [6:0] C_MP1  = 7'b1110111, C_MM1  = 7'b1110010, C_DPA = 7'b0000010;
    localparam logic [2:0] D_NONE = 3'd0, D_M = 3'd1, D_D = 3'd2, D_A = 3'd4, D_AM = 3'd5;
    localparam logic [2:0] J_NO = 3'd0, J_GT = 3'd1, J_EQ = 3'd2, J_LT = 3'd4, J_JMP = 3'd7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst32 = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    hack_cpu_mc_if #(.WIDTH(16)) bus16 ();
    hack_cpu_mc_if #(.WIDTH(32)) bus32 ();
    logic [15:0] pc16;
    logic [31:0] pc32;
    logic        ret16, ret32;

    hack_cpu_mc #(.WIDTH(16), .RESET_VECTOR(16'd0)) u16 (
        .clk(clk), .reset(reset), .bus(bus16), .pc_out(pc16), .retire(ret16));
    hack_cpu_mc #(.WIDTH(32), .RESET_VECTOR(32'd0)) u32 (
        .clk(clk), .reset(rst32), .bus(bus32), .pc_out(pc32), .retire(ret32));

    int total = 0, passed = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [15:0] ainst(input int v);
        return 16'(v) & 16'h7FFF;
    endfunction
    function automatic logic [15:0] cinst(input logic [6:0] c, input logic [2:0] d, input logic [2:0] j);
        return {3'b111, c, d, j};
    endfunction
    function automatic logic [31:0] cinst32(input logic [6:0] c, input logic [2:0] d, input logic [2:0] j);
        return {1'b1, 18'h3FFFF, c, d, j};
    endfunction

    function automatic logic [31:0] rom32(input logic [31:0] a);
        case (a)
            32'd0:        return 32'h7FFF_FFFF;
            32'd1:        return cinst32(C_A, D_D, J_NO);
            32'd2:        return cinst32(C_DP1, D_D, J_NO);
            32'd3:        return cinst32(C_D, D_M, J_NO);
            32'd4:        return cinst32(C_D, D_NONE, J_LT);
            32'h7FFF_FFFF: return cinst32(C_NEG1, D_A, J_NO);
            32'h8000_0000: return cinst32(C_ZERO, D_NONE, J_JMP);
            32'hFFFF_FFFF: return cinst32(C_ZERO, D_D, J_NO);
            default:      return 32'h0;
        endcase
    endfunction

    // Memory models
    logic [15:0] rom16 [0:63];
    logic [15:0] ram16 [0:63];
    logic [7:0]  idly = 8'd0, ddly = 8'd0, icnt = 8'd0, dcnt = 8'd0;
    logic        force_dack = 1'b0;

    always_comb begin
        bus16.imem_ack   = bus16.imem_req && (icnt >= idly);
        bus16.imem_rdata = rom16[bus16.imem_addr[5:0]];
        bus16.dmem_ack   = force_dack || (bus16.dmem_req && (dcnt >= ddly));
        bus16.dmem_rdata = ram16[bus16.dmem_addr[5:0]];
        bus32.imem_ack   = bus32.imem_req;
        bus32.imem_rdata = rom32(bus32.imem_addr);
        bus32.dmem_ack   = bus32.dmem_req;
        bus32.dmem_rdata = 32'h0;
    end

    always @(posedge clk) begin
        icnt <= (bus16.imem_req && !bus16.imem_ack) ? icnt + 8'd1 : 8'd0;
        dcnt <= (bus16.dmem_req && !bus16.dmem_ack) ? dcnt + 8'd1 : 8'd0;
    end

    // Scoreboards and monitors
    wr_t         exp_wr16[$], exp_wr32[$];
    logic [31:0] exp_ret16[$], exp_ret32[$];
    int          ret_cnt16 = 0, ret_cnt32 = 0;
    wr_t         e16, e32;
    logic        d_act = 1'b0, d_first = 1'b0, prev_ack = 1'b0, cap_we = 1'b0;
    logic [14:0] cap_addr;
    logic [15:0] cap_data;

    always @(negedge clk) begin
        if (prev_ack) chk("dreq_drop_after_ack", 32'(bus16.dmem_req), 32'd0);
        if (bus16.dmem_req) begin
            if (!d_act) begin
                d_act = 1'b1; d_first = 1'b1;
                cap_addr = bus16.dmem_addr; cap_data = bus16.dmem_wdata; cap_we = bus16.dmem_we;
            end else d_first = 1'b0;
            if (bus16.dmem_ack) begin
                if (!d_first) begin
                    chk("dhold_addr", 32'(bus16.dmem_addr), 32'(cap_addr));
                    chk("dhold_we", 32'(bus16.dmem_we), 32'(cap_we));
                    if (cap_we) chk("dhold_wdata", 32'(bus16.dmem_wdata), 32'(cap_data));
                end
                d_act = 1'b0;
            end
        end else d_act = 1'b0;
        prev_ack = bus16.dmem_req && bus16.dmem_ack;

        if (bus16.dmem_req && bus16.dmem_we && bus16.dmem_ack) begin
            chk("wr16_expected", 32'(exp_wr16.size() != 0), 32'd1);
            if (exp_wr16.size() != 0) begin
                e16 = exp_wr16.pop_front();
                chk("wr16_addr", 32'(bus16.dmem_addr), e16.addr);
                chk("wr16_data", 32'(bus16.dmem_wdata), e16.data);
            end
        end
        if (ret16) begin
            ret_cnt16++;
            chk("ret16_expected", 32'(exp_ret16.size() != 0), 32'd1);
            if (exp_ret16.size() != 0) chk("ret16_pc", 32'(pc16), exp_ret16.pop_front());
        end
    end

    always @(negedge clk) begin
        if (bus32.dmem_req && bus32.dmem_we && bus32.dmem_ack) begin
            chk("wr32_expected", 32'(exp_wr32.size() != 0), 32'd1);
            if (exp_wr32.size() != 0) begin
                e32 = exp_wr32.pop_front();
                chk("wr32_addr", 32'(bus32.dmem_addr), e32.addr);
                chk("wr32_data", bus32.dmem_wdata, e32.data);
            end
        end
        if (ret32) begin
            ret_cnt32++;
            chk("ret32_expected", 32'(exp_ret32.size() != 0), 32'd1);
            if (exp_ret32.size() != 0) chk("ret32_pc", pc32, exp_ret32.pop_front());
        end
    end

    // Test helpers
    int c0 = 0, base = 0;

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            rom16[i] = 16'h0000;
            ram16[i] = 16'h0000;
        end
    endtask

    task automatic release16(input string name);
        @(posedge clk);
        @(negedge clk);
        chk({name, "_rst_pc"}, 32'(pc16), 32'd0);
        chk({name, "_rst_ireq"}, 32'(bus16.imem_req), 32'd0);
        chk({name, "_rst_dreq"}, 32'(bus16.dmem_req), 32'd0);
        chk({name, "_rst_we"}, 32'(bus16.dmem_we), 32'd0);
        chk({name, "_rst_retire"}, 32'(ret16), 32'd0);
        reset = 1'b0;
        c0 = cyc;
    endtask

    task automatic run16(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (ret_cnt16 >= target) break;
        end
        chk(name, 32'(ret_cnt16 >= target), 32'd1);
    endtask

    task automatic end16(input string name);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_wr_left"}, 32'(exp_wr16.size()), 32'd0);
        chk({name, "_ret_left"}, 32'(exp_ret16.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // @5; D=A; @7; D=D+A; @0; M=D
        clear_mem();
        rom16[0] = ainst(5);  rom16[1] = cinst(C_A, D_D, J_NO);
        rom16[2] = ainst(7);  rom16[3] = cinst(C_DPA, D_D, J_NO);
        rom16[4] = ainst(0);  rom16[5] = cinst(C_D, D_M, J_NO);
        exp_wr16.push_back('{32'd0, 32'd12});
        for (int k = 1; k <= 6; k++) exp_ret16.push_back(32'(k));
        base = ret_cnt16;
        release16("t1");
        run16(base + 6, 200, "t1_done");
        chk("t1_cycles", 32'(cyc - c0), 32'd14);
        chk("t1_pc", 32'(pc16), 32'd6);
        end16("t1");

        // M=M+1 with three wait cycles on read and write
        clear_mem();
        rom16[0] = ainst(3); rom16[1] = cinst(C_MP1, D_M, J_NO);
        ram16[3] = 16'd41;
        ddly = 8'd3;
        exp_wr16.push_back('{32'd3, 32'd42});
        exp_ret16.push_back(32'd1); exp_ret16.push_back(32'd2);
        base = ret_cnt16;
        release16("t2");
        run16(base + 2, 200, "t2_done");
        chk("t2_pc", 32'(pc16), 32'd2);
        end16("t2");

        // JEQ taken, JGT not taken, JMP, JLT taken
        clear_mem();
        rom16[0] = ainst(5);                   rom16[1] = cinst(C_ZERO, D_D, J_NO);
        rom16[2] = cinst(C_D, D_NONE, J_EQ);   rom16[5] = cinst(C_NEG1, D_D, J_NO);
        rom16[6] = cinst(C_D, D_NONE, J_GT);   rom16[7] = ainst(12);
        rom16[8] = cinst(C_ZERO, D_NONE, J_JMP); rom16[12] = cinst(C_D, D_NONE, J_LT);
        ddly = 8'd0; idly = 8'd1;
        exp_ret16.push_back(32'd1); exp_ret16.push_back(32'd2);
        exp_ret16.push_back(32'd5); exp_ret16.push_back(32'd6);
        exp_ret16.push_back(32'd7); exp_ret16.push_back(32'd8);
        exp_ret16.push_back(32'd12); exp_ret16.push_back(32'd12);
        base = ret_cnt16;
        release16("t3");
        run16(base + 8, 300, "t3_done");
        chk("t3_pc", 32'(pc16), 32'd12);
        end16("t3");

        // AM=M-1 writes to the old A; A holds the result afterwards
        clear_mem();
        rom16[0] = ainst(10); rom16[1] = cinst(C_MM1, D_AM, J_NO);
        rom16[2] = cinst(C_A, D_D, J_NO); rom16[3] = ainst(20);
        rom16[4] = cinst(C_D, D_M, J_NO);
        ram16[10] = 16'd4;
        idly = 8'd0; ddly = 8'd1;
        exp_wr16.push_back('{32'd10, 32'd3});
        exp_wr16.push_back('{32'd20, 32'd3});
        for (int k = 1; k <= 5; k++) exp_ret16.push_back(32'(k));
        base = ret_cnt16;
        release16("t4");
        run16(base + 5, 200, "t4_done");
        end16("t4");

        // Reset while stalled in MREAD; late ack must be ignored
        clear_mem();
        rom16[0] = ainst(7); rom16[1] = cinst(C_A, D_D, J_NO);
        rom16[2] = ainst(3); rom16[3] = cinst(C_M, D_D, J_NO);
        ram16[3] = 16'd99;
        ddly = 8'd20;
        for (int k = 1; k <= 3; k++) exp_ret16.push_back(32'(k));
        base = ret_cnt16;
        release16("t5");
        run16(base + 3, 100, "t5_pre");
        for (int i = 0; i < 20; i++) begin
            if (bus16.dmem_req && !bus16.dmem_we) break;
            @(negedge clk);
            #1;
        end
        chk("t5_in_mread", 32'(bus16.dmem_req && !bus16.dmem_we), 32'd1);
        reset = 1'b1;
        rom16[0] = cinst(C_D, D_M, J_NO);
        ddly = 8'd0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        force_dack = 1'b1;
        chk("t5_boot_ireq", 32'(bus16.imem_req), 32'd0);
        chk("t5_boot_dreq", 32'(bus16.dmem_req), 32'd0);
        exp_wr16.push_back('{32'd0, 32'd0});
        exp_ret16.push_back(32'd1);
        base = ret_cnt16;
        @(negedge clk);
        force_dack = 1'b0;
        chk("t5_fetch_req", 32'(bus16.imem_req), 32'd1);
        chk("t5_fetch_addr", 32'(bus16.imem_addr), 32'd0);
        run16(base + 1, 50, "t5_post");
        end16("t5");

        // WIDTH=32: overflow into the sign bit, JLT, PC wrap
        exp_wr32.push_back('{32'h7FFF_FFFF, 32'h8000_0000});
        for (int k = 1; k <= 4; k++) exp_ret32.push_back(32'(k));
        exp_ret32.push_back(32'h7FFF_FFFF); exp_ret32.push_back(32'h8000_0000);
        exp_ret32.push_back(32'hFFFF_FFFF); exp_ret32.push_back(32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_pc", pc32, 32'd0);
        chk("t6_rst_ireq", 32'(bus32.imem_req), 32'd0);
        rst32 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (ret_cnt32 >= 8) break;
        end
        chk("t6_done", 32'(ret_cnt32 >= 8), 32'd1);
        chk("t6_pc_wrap", pc32, 32'd0);
        rst32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_wr_left", 32'(exp_wr32.size()), 32'd0);
        chk("t6_ret_left", 32'(exp_ret32.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hack_cpu_mc.md
Name: hack_cpu_mc

Overview:
Multi-cycle, width-parametrised successor to the single-cycle Hack CPU.
- Fetches instructions and reads/writes data through separate req/ack handshake ports, so it tolerates wait-stated memories (BRAM, SDRAM bridge, memory-mapped I/O).
- Sits between the instruction ROM/arbiter and the data RAM/IO decoder.
- Adds a retire pulse and a stall-tolerant FSM; the original block has neither.

Parameters:
WIDTH, 16, datapath/register/instruction width; must be >= 16.
RESET_VECTOR, 0, PC value loaded on reset.
(Derived localparam ADDR_W = WIDTH-1, the data address width.)

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  WIDTH  fetch address (current PC)
imem_rdata  in  WIDTH  instruction word; valid when imem_ack=1
imem_ack  in  1  fetch complete
dmem_req  out  1  data access request
dmem_we  out  1  1=write, 0=read; valid while dmem_req=1
dmem_addr  out  ADDR_W  data address = A[ADDR_W-1:0]
dmem_wdata  out  WIDTH  ALU result for writes
dmem_rdata  in  WIDTH  read data; valid when dmem_ack=1
dmem_ack  in  1  data access complete
pc_out  out  WIDTH  current PC
retire  out  1  one-cycle pulse as each instruction commits

Behaviour:
- Reset, sampled on a clk edge:
  - PC=RESET_VECTOR; A=0; D=0; IR=0; state=FETCH.
  - All req/we outputs and retire are 0 in the cycle after reset.
  - Reset mid-operation aborts any outstanding access. A late ack is ignored; no register updates.
- Decode:
  - IR[WIDTH-1]=0 is an A-instruction: A <= IR[WIDTH-2:0] zero-extended.
  - Otherwise a C-instruction with fields a=IR[12], zx..no=IR[11:6], dA=IR[5], dD=IR[4], dM=IR[3], j=IR[2:0].
  - Bits IR[WIDTH-2:13] are ignored.
- ALU: x=D; y=(a ? MDR : A). The six Hack control bits apply at WIDTH bits. zr=(out==0); ng=out[WIDTH-1].
- FSM states:
  - FETCH: imem_req=1, imem_addr=PC. Hold until imem_ack=1, then IR<=imem_rdata.
    - Next state is MREAD if it is a C-instruction with a=1.
    - Otherwise EXEC.
  - MREAD: dmem_req=1, dmem_we=0, dmem_addr=A. On dmem_ack, MDR<=dmem_rdata, then go to EXEC.
  - EXEC: one cycle; compute ALU.
    - If dM=1: latch the write address (pre-update A) and the write data, update A/D if selected, then go to MWRITE.
    - Otherwise commit.
  - MWRITE: dmem_req=1, dmem_we=1, with the latched address and data. On dmem_ack, commit.
- Commit, in the same edge as the last EXEC/MWRITE transition:
  - A<=ALU if dA; D<=ALU if dD.
  - PC<=pre-update A if the jump condition is true, else PC+1 (wraps mod 2^WIDTH).
  - retire=1 for one cycle; next state FETCH.
- Jump conditions on (zr,ng):
  - 000 never; 001 !ng&&!zr; 010 zr; 011 !ng; 100 ng; 101 !zr; 110 ng||zr; 111 always.
  - A-instructions never jump.
- Ordering:
  - The jump target and write address always use A as it was before the instruction; Hack semantics, e.g. AM=M+1 writes to the old A.
  - The D/A update and the write are both committed even if the write waits many cycles. Registers update at EXEC; PC and retire wait for the write ack.
- Handshake rules:
  - req, addr, we and wdata stay stable from req rise until the ack cycle inclusive. req drops the cycle after ack.
  - An ack with no req outstanding is ignored.
  - Accesses do not pipeline: at most one outstanding.
- Latency with zero-wait memory (ack in the same cycle as req):
  - A-instruction 2 cycles; C-instruction 2 cycles; +1 for an M read; +1 for an M write.

Decomposition:
- Shared package hack_pkg:
  - state enum {FETCH, MREAD, EXEC, MWRITE};
  - jump-code constants;
  - instruction field bit positions (A_BIT=12, DEST_A=5, DEST_D=4, DEST_M=3, ALU control [11:6], JUMP [2:0]).
- One natural sub-module: hack_alu_w, a WIDTH-parametrised Hack ALU (x, y, six control bits → out, zr, ng).
- Reuse the existing register and program_counter style only through parametrised equivalents inside this module.

Test Plan:
- Reset, then ROM {@5, D=A, @7, D=D+A, @0, M=D}, zero-wait → dmem write addr 0 data 12; retire pulses 6 times; PC=6.
- M=M+1 with dmem_ack delayed 3 cycles on both the read and the write (RAM[3]=41, A=3) → wdata=42 at addr 3; req held stable through the waits; one retire.
- A=5; D=0; D;JEQ → PC=5. D=-1; D;JGT → PC=PC+1. 0;JMP → PC=A.
- AM=M-1 with A=10, RAM[10]=4 → write addr 10 data 3; A=3 afterwards.
- Reset asserted mid-MREAD, then ack arrives → ack ignored; A/D unchanged from reset value 0; next fetch at RESET_VECTOR.
- WIDTH=32: @0x7FFFFFFF; D=A; D=D+1 → D=0x80000000; D;JLT jumps; PC wrap from 0xFFFFFFFF to 0.
